// File: rtl/sm_dbg_ctrl.sv
// Run/halt/step/dump debug controller for the schoolMIPS core.
// Gates the core clock-enable and owns the core's register-read debug port.
module sm_dbg_ctrl #(
    parameter int STEP_CYCLES  = 1,
    parameter int NREGS        = 32,
    parameter int RUN_ON_RESET = 1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        cmd_valid,
    input  logic [1:0]  cmd_op,
    output logic        cmd_ready,
    input  logic        bp_en,
    input  logic [31:0] bp_pc,
    output logic        cpu_en,
    output logic [4:0]  regAddr,
    input  logic [31:0] regData,
    output logic        dump_valid,
    input  logic        dump_ready,
    output logic [4:0]  dump_addr,
    output logic [31:0] dump_data,
    output logic        halted,
    output logic        bp_hit
);

    typedef enum logic [1:0] {
        ST_HALT = 2'd0,
        ST_RUN  = 2'd1,
        ST_STEP = 2'd2,
        ST_DUMP = 2'd3
    } state_t;

    localparam logic [1:0] OP_HALT = 2'd0;
    localparam logic [1:0] OP_RUN  = 2'd1;
    localparam logic [1:0] OP_STEP = 2'd2;
    localparam logic [1:0] OP_DUMP = 2'd3;

    localparam logic [4:0] IDX_LAST   = 5'(NREGS - 1);
    localparam logic [7:0] STEP_LOAD  = 8'(STEP_CYCLES);
    localparam state_t     RESET_ST   = (RUN_ON_RESET != 0) ? ST_RUN : ST_HALT;

    state_t      state_q, state_d;
    logic [4:0]  idx_q, idx_d;
    logic [7:0]  cnt_q, cnt_d;
    logic        skip_q, skip_d;
    logic        bp_hit_q, bp_hit_d;

    logic        cmd_fire;
    logic        bp_match;

    assign cmd_ready = (state_q == ST_HALT) || (state_q == ST_RUN);
    assign cmd_fire  = cmd_valid && cmd_ready;
    // skip lets RUN leave a PC that is sitting on the breakpoint
    assign bp_match  = bp_en && (regData == bp_pc) && !skip_q;

    always_comb begin
        state_d    = state_q;
        idx_d      = idx_q;
        cnt_d      = cnt_q;
        skip_d     = skip_q;
        bp_hit_d   = bp_hit_q;
        cpu_en     = 1'b0;
        regAddr    = 5'd0;
        dump_valid = 1'b0;

        unique case (state_q)
            ST_HALT: begin
                if (cmd_fire) begin
                    unique case (cmd_op)
                        OP_RUN: begin
                            state_d  = ST_RUN;
                            skip_d   = 1'b1;
                            bp_hit_d = 1'b0;
                        end
                        OP_STEP: begin
                            state_d  = ST_STEP;
                            cnt_d    = STEP_LOAD;
                            bp_hit_d = 1'b0;
                        end
                        OP_DUMP: begin
                            state_d = ST_DUMP;
                            idx_d   = 5'd0;
                        end
                        default: ;
                    endcase
                end
            end
            ST_RUN: begin
                cpu_en = !bp_match;
                skip_d = 1'b0;
                if (cmd_fire && (cmd_op == OP_RUN || cmd_op == OP_STEP))
                    bp_hit_d = 1'b0;
                // breakpoint outranks a simultaneous HALT command
                if (bp_match) begin
                    state_d  = ST_HALT;
                    bp_hit_d = 1'b1;
                end else if (cmd_fire && cmd_op == OP_HALT) begin
                    state_d = ST_HALT;
                end
            end
            ST_STEP: begin
                cpu_en = 1'b1;
                cnt_d  = cnt_q - 8'd1;
                if (cnt_q <= 8'd1) begin
                    state_d = ST_HALT;
                    cnt_d   = 8'd0;
                end
            end
            ST_DUMP: begin
                regAddr    = idx_q;
                dump_valid = 1'b1;
                if (dump_ready) begin
                    if (idx_q == IDX_LAST) begin
                        state_d = ST_HALT;
                        idx_d   = 5'd0;
                    end else begin
                        idx_d = idx_q + 5'd1;
                    end
                end
            end
            default: state_d = ST_HALT;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= RESET_ST;
            idx_q    <= 5'd0;
            cnt_q    <= 8'd0;
            skip_q   <= 1'b1;
            bp_hit_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            idx_q    <= idx_d;
            cnt_q    <= cnt_d;
            skip_q   <= skip_d;
            bp_hit_q <= bp_hit_d;
        end
    end

    assign dump_addr = idx_q;
    assign dump_data = regData;
    assign halted    = (state_q == ST_HALT);
    assign bp_hit    = bp_hit_q;

endmodule

// File: tb/tb_sm_dbg_ctrl.sv
// Directed bench for sm_dbg_ctrl: two instances (run-on-reset and halt-on-reset)
// each driving a small PC/register-file core stand-in.
module tb_sm_dbg_ctrl;

    localparam logic [1:0] OP_HALT = 2'd0;
    localparam logic [1:0] OP_RUN  = 2'd1;
    localparam logic [1:0] OP_STEP = 2'd2;
    localparam logic [1:0] OP_DUMP = 2'd3;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        cmd_valid = 1'b0;
    logic [1:0]  cmd_op = 2'd0;
    logic        bp_en = 1'b0;
    logic [31:0] bp_pc = 32'd0;
    logic        dump_ready = 1'b0;

    logic        cmd_ready_a, cpu_en_a, dump_valid_a, halted_a, bp_hit_a;
    logic [4:0]  reg_addr_a, dump_addr_a;
    logic [31:0] reg_data_a, dump_data_a;
    logic        cmd_ready_b, cpu_en_b, dump_valid_b, halted_b, bp_hit_b;
    logic [4:0]  reg_addr_b, dump_addr_b;
    logic [31:0] reg_data_b, dump_data_b;

    logic [31:0] pc_a, pc_b;
    int          en_cnt_b;

    typedef struct packed {
        logic [4:0]  addr;
        logic [31:0] data;
    } dump_word_t;

    dump_word_t  dump_q[$];
    logic [31:0] step_q[$];

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    function automatic logic [31:0] reg_val(input logic [4:0] addr, input logic [31:0] pc);
        return (addr == 5'd0) ? pc : (32'hC0DE_0000 | {27'd0, addr});
    endfunction

    assign reg_data_a = reg_val(reg_addr_a, pc_a);
    assign reg_data_b = reg_val(reg_addr_b, pc_b);

    always @(posedge clk) begin
        if (rst) begin
            pc_a     <= 32'd0;
            pc_b     <= 32'd0;
            en_cnt_b <= 0;
        end else begin
            if (cpu_en_a) pc_a <= pc_a + 32'd1;
            if (cpu_en_b) begin
                pc_b     <= pc_b + 32'd1;
                en_cnt_b <= en_cnt_b + 1;
            end
        end
    end

    sm_dbg_ctrl #(.STEP_CYCLES(1), .NREGS(32), .RUN_ON_RESET(1)) dut_a (
        .clk(clk), .rst(rst), .cmd_valid(cmd_valid), .cmd_op(cmd_op), .cmd_ready(cmd_ready_a),
        .bp_en(bp_en), .bp_pc(bp_pc), .cpu_en(cpu_en_a), .regAddr(reg_addr_a), .regData(reg_data_a),
        .dump_valid(dump_valid_a), .dump_ready(dump_ready), .dump_addr(dump_addr_a),
        .dump_data(dump_data_a), .halted(halted_a), .bp_hit(bp_hit_a)
    );

    sm_dbg_ctrl #(.STEP_CYCLES(1), .NREGS(32), .RUN_ON_RESET(0)) dut_b (
        .clk(clk), .rst(rst), .cmd_valid(cmd_valid), .cmd_op(cmd_op), .cmd_ready(cmd_ready_b),
        .bp_en(bp_en), .bp_pc(bp_pc), .cpu_en(cpu_en_b), .regAddr(reg_addr_b), .regData(reg_data_b),
        .dump_valid(dump_valid_b), .dump_ready(dump_ready), .dump_addr(dump_addr_b),
        .dump_data(dump_data_b), .halted(halted_b), .bp_hit(bp_hit_b)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    // one-cycle command strobe; checks readiness on the selected instance
    task automatic send(input logic [1:0] op, input bit use_b);
        cmd_valid = 1'b1;
        cmd_op    = op;
        #1;
        check(use_b ? "cmd_ready_b" : "cmd_ready_a", use_b ? cmd_ready_b : cmd_ready_a, 1);
        cyc();
        cmd_valid = 1'b0;
        $display("cmd op=%0d to %s accepted", op, use_b ? "b" : "a");
    endtask

    task automatic push_dump(input logic [31:0] pc);
        for (int i = 0; i < 32; i++) begin
            dump_word_t w;
            w.addr = 5'(i);
            w.data = (i == 0) ? pc : (32'hC0DE_0000 | i);
            dump_q.push_back(w);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        int en_seen;
        logic [31:0] exp_pc;
        dump_word_t  w;

        // reset state of both instances
        rst = 1'b1;
        cyc(); cyc();
        rst = 1'b0;
        check("rst_b_cpu_en",  cpu_en_b, 0);
        check("rst_b_halted",  halted_b, 1);
        check("rst_b_ready",   cmd_ready_b, 1);
        check("rst_b_regaddr", reg_addr_b, 0);
        check("rst_b_dvalid",  dump_valid_b, 0);
        check("rst_b_daddr",   dump_addr_b, 0);
        check("rst_b_bphit",   bp_hit_b, 0);
        check("rst_a_cpu_en",  cpu_en_a, 1);
        check("rst_a_halted",  halted_a, 0);
        check("rst_a_ready",   cmd_ready_a, 1);

        // three single steps on the halt-on-reset instance
        for (int k = 1; k <= 3; k++) begin
            step_q.push_back(32'(k));
            send(OP_STEP, 1'b1);
            check("step_cpu_en", cpu_en_b, 1);
            cyc();
            exp_pc = step_q.pop_front();
            check("step_halted", halted_b, 1);
            check("step_pc", pc_b, exp_pc);
            $display("step %0d: pc=%0d halted=%0d", k, pc_b, halted_b);
            cyc();
        end
        check("step_pulses", en_cnt_b, 3);

        // breakpoint at PC 5 from a fresh run
        bp_en = 1'b1;
        bp_pc = 32'd5;
        rst = 1'b1;
        cyc();
        rst = 1'b0;
        n = 0;
        while (pc_a != 32'd5 && n < 20) begin cyc(); n++; end
        check("bp_reach", pc_a, 5);
        check("bp_cpu_en", cpu_en_a, 0);
        cyc();
        check("bp_halted", halted_a, 1);
        check("bp_hit_set", bp_hit_a, 1);
        for (int i = 0; i < 10; i++) cyc();
        check("bp_pc_hold", pc_a, 5);
        $display("breakpoint: pc=%0d bp_hit=%0d", pc_a, bp_hit_a);
        send(OP_RUN, 1'b0);
        check("resume_cpu_en", cpu_en_a, 1);
        check("resume_bphit", bp_hit_a, 0);
        cyc();
        check("resume_pc", pc_a, 6);
        check("resume_running", halted_a, 0);

        // HALT command while running at PC 7
        n = 0;
        while (pc_a != 32'd7 && n < 20) begin cyc(); n++; end
        check("halt_reach", pc_a, 7);
        cmd_valid = 1'b1;
        cmd_op    = OP_HALT;
        #1;
        check("halt_accept_en", cpu_en_a, 1);
        cyc();
        cmd_valid = 1'b0;
        cyc(); cyc();
        check("halt_pc", pc_a, 8);
        check("halt_halted", halted_a, 1);
        check("halt_bphit", bp_hit_a, 0);
        $display("halt cmd: pc=%0d halted=%0d", pc_a, halted_a);

        // commands offered during STEP are refused
        send(OP_STEP, 1'b0);
        cmd_valid = 1'b1;
        cmd_op    = OP_DUMP;
        #1;
        check("step_busy_ready", cmd_ready_a, 0);
        cyc();
        cmd_valid = 1'b0;
        check("step2_halted", halted_a, 1);
        check("step2_pc", pc_a, 9);
        check("step2_no_dump", dump_valid_a, 0);

        // full dump with dump_ready toggling
        push_dump(pc_a);
        send(OP_DUMP, 1'b0);
        n = 0;
        en_seen = 0;
        while (dump_q.size() > 0 && n < 200) begin
            dump_ready = n[0];
            #1;
            if (cpu_en_a) en_seen++;
            if (dump_valid_a && dump_ready) begin
                w = dump_q.pop_front();
                check("dump_addr", dump_addr_a, w.addr);
                check("dump_data", dump_data_a, w.data);
                $display("dump word addr=%0d data=%h", dump_addr_a, dump_data_a);
            end
            cyc();
            n++;
        end
        dump_ready = 1'b0;
        check("dump_left", dump_q.size(), 0);
        check("dump_cpu_en", en_seen, 0);
        check("dump_halted", halted_a, 1);
        dump_q.delete();

        // breakpoint and HALT command in the same cycle
        bp_pc = 32'd4;
        rst = 1'b1;
        cyc();
        rst = 1'b0;
        n = 0;
        while (pc_a != 32'd4 && n < 20) begin cyc(); n++; end
        check("sim_reach", pc_a, 4);
        check("sim_cpu_en", cpu_en_a, 0);
        cmd_valid = 1'b1;
        cmd_op    = OP_HALT;
        cyc();
        cmd_valid = 1'b0;
        check("sim_halted", halted_a, 1);
        check("sim_bphit", bp_hit_a, 1);
        check("sim_pc", pc_a, 4);
        $display("simultaneous: pc=%0d bp_hit=%0d", pc_a, bp_hit_a);

        // reset aborts a dump at idx 10
        bp_en = 1'b0;
        dump_ready = 1'b1;
        send(OP_DUMP, 1'b0);
        n = 0;
        while (dump_addr_a != 5'd10 && n < 40) begin cyc(); n++; end
        check("abort_reach", dump_addr_a, 10);
        rst = 1'b1;
        cyc();
        check("abort_dvalid", dump_valid_a, 0);
        check("abort_daddr", dump_addr_a, 0);
        rst = 1'b0;
        send(OP_HALT, 1'b0);
        check("abort_halt_pc", pc_a, 1);
        push_dump(pc_a);
        send(OP_DUMP, 1'b0);
        for (int i = 0; i < 32; i++) begin
            check("redump_valid", dump_valid_a, 1);
            w = dump_q.pop_front();
            check("redump_addr", dump_addr_a, w.addr);
            check("redump_data", dump_data_a, w.data);
            $display("redump word addr=%0d data=%h", dump_addr_a, dump_data_a);
            cyc();
        end
        check("redump_halted", halted_a, 1);
        dump_ready = 1'b0;

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
